// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use interlock, branch flush,
// multi-cycle data-memory wait with a sticky timeout, and a saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_Rt_i,
  input  logic [4:0]       IFID_Rs_i,
  input  logic [4:0]       IFID_Rt_i,
  input  logic             Branch_taken_i,
  input  logic             MemAccess_i,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  output logic             PCWrite_o,
  output logic             IFID_en_o,
  output logic             IFID_flush_o,
  output logic             IDEX_en_o,
  output logic             IDEX_bubble_o,
  output logic             EXMEM_en_o,
  output logic             MEMWB_en_o,
  output logic             MEMWB_bubble_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] stall_q;
  logic             load_use;

  assign load_use = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                    ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    dmem_req_o     = 1'b0;
    PCWrite_o      = 1'b0;
    IFID_en_o      = 1'b0;
    IFID_flush_o   = 1'b0;
    IDEX_en_o      = 1'b0;
    IDEX_bubble_o  = 1'b0;
    EXMEM_en_o     = 1'b0;
    MEMWB_en_o     = 1'b0;
    MEMWB_bubble_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        RUN, MEM_WAIT: begin
          dmem_req_o = (state_q == MEM_WAIT) || MemAccess_i;
          if (dmem_req_o && !dmem_ack_i) begin
            // Freeze the front of the pipe; MEM/WB drains a bubble so WB never repeats.
            MEMWB_en_o     = 1'b1;
            MEMWB_bubble_o = 1'b1;
            if (state_q == RUN) begin
              state_d = MEM_WAIT;
              wait_d  = WW'(1);
            end else if (wait_q == WW'(MEM_TIMEOUT)) begin
              state_d = TIMEOUT;
            end else begin
              wait_d = wait_q + 1'b1;
            end
          end else begin
            state_d    = RUN;
            wait_d     = '0;
            IDEX_en_o  = 1'b1;
            EXMEM_en_o = 1'b1;
            MEMWB_en_o = 1'b1;
            if (load_use) begin
              // Branch is not flushed here: it is re-evaluated next cycle with forwarded data.
              IDEX_bubble_o = 1'b1;
            end else begin
              PCWrite_o    = 1'b1;
              IFID_en_o    = 1'b1;
              IFID_flush_o = Branch_taken_i;
            end
          end
        end
        default: state_d = TIMEOUT;
      endcase
    end
  end

  assign timeout_o   = !rst_i && (state_q == TIMEOUT);
  assign stall_cnt_o = rst_i ? '0 : stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (!PCWrite_o && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4 and CNT_W=4.
module tb_pipeline_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i, IDEX_MemRead_i, Branch_taken_i, MemAccess_i, dmem_ack_i;
  logic [4:0] IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i;
  logic       dmem_req_o, PCWrite_o, IFID_en_o, IFID_flush_o, IDEX_en_o, IDEX_bubble_o;
  logic       EXMEM_en_o, MEMWB_en_o, MEMWB_bubble_o, timeout_o;
  logic [3:0] stall_cnt_o;

  int errors = 0;
  int checks = 0;

  // {req, PCWrite, IFID_en, IFID_flush, IDEX_en, IDEX_bubble, EXMEM_en, MEMWB_en, MEMWB_bubble, timeout}
  localparam logic [9:0] C_RESET   = 10'b0000000000;
  localparam logic [9:0] C_NORMAL  = 10'b0110101100;
  localparam logic [9:0] C_LOADUSE = 10'b0000111100;
  localparam logic [9:0] C_BRANCH  = 10'b0111101100;
  localparam logic [9:0] C_FREEZE  = 10'b1000000110;
  localparam logic [9:0] C_MEMACK  = 10'b1110101100;
  localparam logic [9:0] C_MEMBR   = 10'b1111101100;
  localparam logic [9:0] C_TIMEOUT = 10'b0000000001;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_Rt_i(IDEX_Rt_i),
    .IFID_Rs_i(IFID_Rs_i), .IFID_Rt_i(IFID_Rt_i),
    .Branch_taken_i(Branch_taken_i), .MemAccess_i(MemAccess_i), .dmem_ack_i(dmem_ack_i),
    .dmem_req_o(dmem_req_o), .PCWrite_o(PCWrite_o), .IFID_en_o(IFID_en_o),
    .IFID_flush_o(IFID_flush_o), .IDEX_en_o(IDEX_en_o), .IDEX_bubble_o(IDEX_bubble_o),
    .EXMEM_en_o(EXMEM_en_o), .MEMWB_en_o(MEMWB_en_o), .MEMWB_bubble_o(MEMWB_bubble_o),
    .timeout_o(timeout_o), .stall_cnt_o(stall_cnt_o)
  );

  function automatic logic [9:0] ctl();
    return {dmem_req_o, PCWrite_o, IFID_en_o, IFID_flush_o, IDEX_en_o, IDEX_bubble_o,
            EXMEM_en_o, MEMWB_en_o, MEMWB_bubble_o, timeout_o};
  endfunction

  task automatic step(input logic rst, input logic mr, input logic [4:0] idrt,
                      input logic [4:0] ifrs, input logic [4:0] ifrt,
                      input logic br, input logic ma, input logic ack);
    @(negedge clk_i);
    rst_i = rst; IDEX_MemRead_i = mr; IDEX_Rt_i = idrt; IFID_Rs_i = ifrs; IFID_Rt_i = ifrt;
    Branch_taken_i = br; MemAccess_i = ma; dmem_ack_i = ack;
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = ctl();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: controls got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] exp);
    checks++;
    assert (stall_cnt_o === exp) else begin
      errors++;
      $error("FAIL %s: stall_cnt got %0d expected %0d", tag, stall_cnt_o, exp);
    end
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("reset_ctl", C_RESET); chk_cnt("reset_cnt", 4'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("idle", C_NORMAL); chk_cnt("idle_cnt", 4'd0);

    // load-use on rs, then on rt
    step(0, 1, 5'd2, 5'd2, 5'd7, 0, 0, 0);
    chk_ctl("lu_rs", C_LOADUSE);
    step(0, 1, 5'd5, 5'd1, 5'd5, 0, 0, 0);
    chk_ctl("lu_rt", C_LOADUSE); chk_cnt("lu_cnt1", 4'd1);
    step(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    chk_ctl("lu_rt0", C_NORMAL); chk_cnt("lu_cnt2", 4'd2);
    step(0, 0, 5'd3, 5'd3, 5'd3, 0, 0, 0);
    chk_ctl("no_memread", C_NORMAL);

    // branch alone, then branch with load-use
    step(0, 0, 0, 0, 0, 1, 0, 0);
    chk_ctl("branch", C_BRANCH);
    step(0, 1, 5'd4, 5'd4, 5'd0, 1, 0, 0);
    chk_ctl("branch_lu", C_LOADUSE);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk_cnt("branch_cnt", 4'd3);

    // memory access, ack on 4th cycle
    step(0, 0, 0, 0, 0, 0, 1, 0); chk_ctl("mem_c1", C_FREEZE);
    step(0, 0, 0, 0, 0, 0, 1, 0); chk_ctl("mem_c2", C_FREEZE);
    step(0, 0, 0, 0, 0, 0, 1, 0); chk_ctl("mem_c3", C_FREEZE);
    step(0, 0, 0, 0, 0, 0, 1, 1); chk_ctl("mem_ack", C_MEMACK);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("mem_after", C_NORMAL); chk_cnt("mem_cnt", 4'd6);

    // same-cycle ack, then wait ending in ack with a taken branch
    step(0, 0, 0, 0, 0, 0, 1, 1); chk_ctl("mem_fast", C_MEMACK);
    step(0, 0, 0, 0, 0, 0, 1, 0); chk_ctl("mem_w1", C_FREEZE);
    step(0, 0, 0, 0, 0, 1, 0, 1); chk_ctl("mem_ack_br", C_MEMBR);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("mem_ack_br_run", C_NORMAL); chk_cnt("mem_br_cnt", 4'd7);

    // timeout: memory wait outranks load-use; 4 wait cycles then sticky timeout
    step(0, 1, 5'd6, 5'd6, 5'd0, 1, 1, 0); chk_ctl("mem_over_lu", C_FREEZE);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0); chk_ctl("to_wait", C_FREEZE);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("to_enter", C_TIMEOUT); chk_cnt("to_cnt", 4'd12);
    step(0, 0, 0, 0, 0, 1, 1, 1); chk_ctl("to_sticky", C_TIMEOUT);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    chk_cnt("sat_cnt", 4'd15);
    step(1, 0, 0, 0, 0, 0, 0, 0); chk_ctl("to_rst", C_RESET);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("to_cleared", C_NORMAL); chk_cnt("to_cnt_clr", 4'd0);

    // reset in the middle of a memory wait, late ack ignored
    step(0, 0, 0, 0, 0, 0, 1, 0); chk_ctl("mw_c1", C_FREEZE);
    step(0, 0, 0, 0, 0, 0, 1, 0); chk_ctl("mw_c2", C_FREEZE);
    step(1, 0, 0, 0, 0, 0, 1, 0); chk_ctl("mw_rst", C_RESET);
    step(0, 0, 0, 0, 0, 0, 0, 1); chk_ctl("mw_late_ack", C_NORMAL);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk_ctl("mw_run", C_NORMAL); chk_cnt("mw_cnt", 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
